// File: rtl/conv33_pkg.sv
// Shared constants and FSM state encoding for the conv33 bias loader.
// Default widths and the acknowledge timeout live here so the top and bench agree.
package conv33_pkg;

    localparam int BIAS_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF  = 6;
    localparam int ACK_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_RD  = 3'd2,
        S_LOAD     = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_HOLD     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/conv33_bias_loader.sv
// Per-channel bias fetch/load sequencer for a 3x3 conv engine; all outputs registered.
// Optional ack watchdog enabled by defining CONV33_BIAS_ACK_TIMEOUT_EN.
module conv33_bias_loader
    import conv33_pkg::*;
#(
    parameter int BIAS_WIDTH  = BIAS_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_ch,
    input  logic                  ch_done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BIAS_WIDTH-1:0] mem_rd_data,
    output logic                  load_en,
    output logic [BIAS_WIDTH-1:0] load_data,
    input  logic                  bias_load,
    output logic [ADDR_WIDTH-1:0] ch_idx,
    output logic                  ch_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_num;
    logic [ADDR_WIDTH-1:0] r_ch_idx;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [BIAS_WIDTH-1:0] r_load_data;
    logic                  r_mem_rd_en;
    logic                  r_load_en;
    logic                  r_ch_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_last_ch;

`ifdef CONV33_BIAS_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign w_last_ch = (r_ch_idx == (r_num - ONE));

    // Outputs are set on the transition into the state that owns them, so
    // mem_rd_en is high during FETCH and load_en during LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num       <= '0;
            r_ch_idx    <= '0;
            r_mem_addr  <= '0;
            r_load_data <= '0;
            r_mem_rd_en <= 1'b0;
            r_load_en   <= 1'b0;
            r_ch_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef CONV33_BIAS_ACK_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_mem_rd_en <= 1'b0;
            r_load_en   <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base   <= base_addr;
                        r_num    <= num_ch;
                        r_ch_idx <= '0;
                        r_busy   <= 1'b1;
`ifdef CONV33_BIAS_ACK_TIMEOUT_EN
                        r_err    <= 1'b0;
`endif
                        if (num_ch == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_FETCH;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= base_addr;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    r_load_data <= mem_rd_data;
                    r_load_en   <= 1'b1;
                    r_state     <= S_LOAD;
                end
                S_LOAD: begin
                    r_state <= S_WAIT_ACK;
`ifdef CONV33_BIAS_ACK_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WAIT_ACK: begin
                    if (bias_load) begin
                        r_ch_ready <= 1'b1;
                        r_state    <= S_HOLD;
                    end
`ifdef CONV33_BIAS_ACK_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (ch_done) begin
                        r_ch_ready <= 1'b0;
                        if (w_last_ch) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ch_idx    <= r_ch_idx + ONE;
                            r_mem_addr  <= r_base + r_ch_idx + ONE;
                            r_mem_rd_en <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign load_en   = r_load_en;
    assign load_data = r_load_data;
    assign ch_idx    = r_ch_idx;
    assign ch_ready  = r_ch_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conv33_bias_loader.sv
// Directed bench for conv33_bias_loader: memory and ack models plus a load scoreboard.
// Timeout scenario runs only when CONV33_BIAS_ACK_TIMEOUT_EN is defined.
module tb_conv33_bias_loader;

    localparam int BW = 16;
    localparam int AW = 6;
    localparam int W  = AW + AW + BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] num_ch;
    logic          ch_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_rd_data = '0;
    logic          load_en;
    logic [BW-1:0] load_data;
    logic          bias_load;
    logic [AW-1:0] ch_idx;
    logic          ch_ready;
    logic          busy;
    logic          done;
    logic          err;

    logic [BW-1:0] mem [64];
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] last_rd_addr;
    logic          ack_en;
    logic          ack_pending;
    int            n_checks;
    int            n_errors;
    int            done_cnt;
    int            load_cnt;

    conv33_bias_loader #(.BIAS_WIDTH(BW), .ADDR_WIDTH(AW), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_ch(num_ch),
        .ch_done(ch_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .load_en(load_en), .load_data(load_data),
        .bias_load(bias_load), .ch_idx(ch_idx), .ch_ready(ch_ready), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous bias memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock, then sample at the falling edge and run the models.
    task automatic tick();
        logic [W-1:0] e;
        @(posedge clk);
        @(negedge clk);
        bias_load   = ack_pending;
        ack_pending = load_en && ack_en;
        if (mem_rd_en) last_rd_addr = mem_addr;
        if (done) done_cnt++;
        if (load_en) begin
            load_cnt++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_unexpected_load: observed=%0h expected=none", load_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_load", {ch_idx, last_rd_addr, load_data}, e);
            end
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            exp_q.push_back({AW'(i), a, mem[a]});
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!ch_ready && k < 40) begin
            tick();
            k++;
        end
        chk(tag, ch_ready, 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        chk(tag, done, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_load_en"}, load_en, 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_ch_idx"}, ch_idx, 0);
        chk({tag, "_ch_ready"}, ch_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] n);
        base_addr = base;
        num_ch    = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_seq(input logic [AW-1:0] base, input int n, input string tag);
        int d0 = done_cnt;
        int l0 = load_cnt;
        push_exp(base, n);
        do_start(base, AW'(n));
        chk({tag, "_err_clear"}, err, 0);
        for (int i = 0; i < n; i++) begin
            wait_ready({tag, "_ready"});
            chk({tag, "_ch_idx"}, ch_idx, i);
            ch_done = 1'b1;
            tick();
            ch_done = 1'b0;
        end
        wait_done({tag, "_done"});
        chk({tag, "_busy_at_done"}, busy, 0);
        tick();
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_load_pulses"}, load_cnt - l0, n);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int l0;
        n_checks = 0; n_errors = 0; done_cnt = 0; load_cnt = 0;
        ack_en = 1'b1; ack_pending = 1'b0; bias_load = 1'b0; last_rd_addr = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_ch = '0; ch_done = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = BW'($urandom_range(0, 16'hffff));
        mem[5] = 16'h1234;

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single channel with exact latency
        push_exp(6'd5, 1);
        d0 = done_cnt;
        do_start(6'd5, 6'd1);
        chk("c1_mem_rd_en", mem_rd_en, 1);
        chk("c1_mem_addr", mem_addr, 5);
        chk("c1_busy", busy, 1);
        tick();
        chk("c2_mem_rd_en_low", mem_rd_en, 0);
        chk("c2_load_en_low", load_en, 0);
        tick();
        chk("c3_load_en", load_en, 1);
        chk("c3_load_data", load_data, 16'h1234);
        tick();
        chk("c4_load_en_low", load_en, 0);
        chk("c4_ch_ready_low", ch_ready, 0);
        tick();
        chk("c5_ch_ready", ch_ready, 1);
        chk("c5_load_data_held", load_data, 16'h1234);
        ch_done = 1'b1;
        tick();
        ch_done = 1'b0;
        chk("single_ready_drop", ch_ready, 0);
        chk("single_done_not_yet", done, 0);
        tick();
        chk("single_done", done, 1);
        chk("single_busy_low", busy, 0);
        tick();
        chk("single_done_one_cycle", done, 0);
        chk("single_done_count", done_cnt - d0, 1);

        // Three channels, then wrap-around
        run_seq(6'd10, 3, "three");
        run_seq(6'd63, 2, "wrap");

        // Zero channels: straight to DONE
        l0 = load_cnt;
        do_start(6'd7, 6'd0);
        chk("zero_busy", busy, 1);
        chk("zero_no_rd", mem_rd_en, 0);
        chk("zero_done_early", done, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_busy_low", busy, 0);
        chk("zero_no_load", load_cnt - l0, 0);
        tick();

        // Interference during WAIT_ACK
        ack_en = 1'b0;
        push_exp(6'd20, 1);
        d0 = done_cnt;
        l0 = load_cnt;
        do_start(6'd20, 6'd1);
        tick();
        tick();
        tick();
        start = 1'b1; base_addr = 6'd40; num_ch = 6'd5; ch_done = 1'b1;
        tick();
        start = 1'b0; ch_done = 1'b0;
        chk("intf_ready_low", ch_ready, 0);
        chk("intf_busy", busy, 1);
        chk("intf_no_rd", mem_rd_en, 0);
        tick();
        chk("intf_still_waiting", ch_ready, 0);
        bias_load = 1'b1;
        tick();
        ack_en = 1'b1;
        chk("intf_ready", ch_ready, 1);
        chk("intf_ch_idx", ch_idx, 0);
        ch_done = 1'b1;
        tick();
        ch_done = 1'b0;
        wait_done("intf_done");
        tick();
        chk("intf_done_count", done_cnt - d0, 1);
        chk("intf_load_count", load_cnt - l0, 1);

        // Reset during HOLD of channel 1
        push_exp(6'd30, 3);
        do_start(6'd30, 6'd3);
        wait_ready("rstmid_ready0");
        ch_done = 1'b1;
        tick();
        ch_done = 1'b0;
        wait_ready("rstmid_ready1");
        chk("rstmid_ch_idx", ch_idx, 1);
        d0 = done_cnt;
        l0 = load_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rstmid");
        for (int i = 0; i < 10; i++) tick();
        chk("rstmid_no_done", done_cnt - d0, 0);
        chk("rstmid_no_load", load_cnt - l0, 0);
        chk("rstmid_idle", busy, 0);
        exp_q.delete();
        run_seq(6'd2, 1, "after_rst");

        // Maximum channel count
        run_seq(6'd0, 63, "max");

`ifdef CONV33_BIAS_ACK_TIMEOUT_EN
        // Withheld acknowledge
        ack_en = 1'b0;
        push_exp(6'd9, 1);
        d0 = done_cnt;
        do_start(6'd9, 6'd1);
        for (int i = 0; i < 17; i++) tick();
        chk("to_err_before", err, 0);
        chk("to_busy_before", busy, 1);
        tick();
        chk("to_err_set", err, 1);
        chk("to_idle", busy, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("to_err_sticky", err, 1);
        chk("to_no_done", done_cnt - d0, 0);
        ack_en = 1'b1;
        run_seq(6'd9, 1, "to_restart");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/conv33_bias_loader.md
CONV33_BIAS_LOADER -- requirements
Module: conv33_bias_loader

Interface
REQ-001 Parameters SHALL be: BIAS_WIDTH, default 16, bias word width; ADDR_WIDTH, default 6, bias memory address and channel index width; ACK_TIMEOUT, default 15, maximum number of cycles to wait for bias_load.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
- clk  in  1  single clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a bias sequence.
- base_addr  in  ADDR_WIDTH  memory address of the channel-0 bias, sampled on start.
- num_ch  in  ADDR_WIDTH  channel count, sampled on start.
- ch_done  in  1  conv engine finished the current channel.
- mem_rd_en  out  1  bias memory read strobe.
- mem_addr  out  ADDR_WIDTH  bias memory address.
- mem_rd_data  in  BIAS_WIDTH  memory data, valid 1 cycle after mem_rd_en.
- load_en  out  1  write strobe to the bias buffer.
- load_data  out  BIAS_WIDTH  bias word to the buffer.
- bias_load  in  1  buffer acknowledge, a 1-cycle pulse.
- ch_idx  out  ADDR_WIDTH  current channel index.
- ch_ready  out  1  current channel bias is loaded; the engine may run.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse when the sequence completes.
- err  out  1  sticky timeout flag (macro-dependent).

Function
REQ-003 The block SHALL use the FSM states IDLE, FETCH, WAIT_RD, LOAD, WAIT_ACK, HOLD and DONE, and SHALL register every output.
REQ-004 In IDLE, start=1 SHALL latch base_addr and num_ch, clear ch_idx and err, and move to FETCH; if num_ch==0 it SHALL move straight to DONE instead.
REQ-005 FETCH SHALL drive mem_rd_en=1 for exactly one cycle with mem_addr=(base_addr+ch_idx) mod 2^ADDR_WIDTH (wrap-around), then move to WAIT_RD.
REQ-006 WAIT_RD SHALL capture mem_rd_data into load_data at the end of its cycle, then move to LOAD.
REQ-007 LOAD SHALL drive load_en=1 for exactly one cycle with load_data stable, then move to WAIT_ACK.
REQ-008 load_data SHALL hold its value from LOAD until the next WAIT_RD capture.
REQ-009 WAIT_ACK SHALL move to HOLD on bias_load=1; bias_load seen in any other state SHALL be ignored.
REQ-010 HOLD SHALL assert ch_ready=1. On ch_done=1:
- if ch_idx==num_ch-1, deassert ch_ready and go to DONE;
- otherwise increment ch_idx, deassert ch_ready and go to FETCH.
REQ-011 ch_done outside HOLD SHALL be ignored.
REQ-012 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-013 start while busy=1 SHALL be ignored, and the latched parameters SHALL NOT change.
REQ-014 Latency SHALL be fixed: with start sampled at edge 0 and bias_load returned 1 cycle after load_en:
- mem_rd_en is high during cycle 1;
- load_en is high during cycle 3;
- ch_ready rises in cycle 5.
REQ-015 Each subsequent channel SHALL add the same 5-cycle load gap after ch_done.
REQ-016 With num_ch at its maximum (2^ADDR_WIDTH-1), ch_idx SHALL count to num_ch-1 without overflow.

Reset
REQ-017 rst=1 at a clock edge SHALL force IDLE and zero every output, including ch_idx, load_data, mem_addr and err, and the latched parameters.
REQ-018 rst asserted mid-sequence SHALL abort the sequence with no done pulse.
REQ-019 load_en and mem_rd_en SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-020 With CONV33_BIAS_ACK_TIMEOUT_EN defined:
- a cycle counter SHALL run in WAIT_ACK;
- if bias_load has not arrived after ACK_TIMEOUT cycles, err SHALL be set (sticky until the next start or rst) and the FSM SHALL go to IDLE without a done pulse.
REQ-021 Without CONV33_BIAS_ACK_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, err SHALL be tied to 0, and no counter SHALL be instantiated.

Structure
REQ-022 Package conv33_pkg SHALL hold:
- the FSM state encoding;
- the default BIAS_WIDTH and ADDR_WIDTH constants;
- the default ACK_TIMEOUT constant.
REQ-023 No sub-module SHALL be used; the FSM, channel counter and timeout counter are inline.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Single channel: base_addr=5, num_ch=1, mem[5]=0x1234, ack 1 cycle after load_en -> mem_addr=5 in cycle 1, load_data=0x1234 with load_en in cycle 3, ch_ready in cycle 5; ch_done -> done pulse, busy=0.
- Three channels: base_addr=10, num_ch=3 -> mem_addr sequence 10, 11, 12, ch_idx 0..2, three load_en pulses, one done.
- Wrap and zero count: base_addr=63, num_ch=2 -> mem_addr 63 then 0; separately num_ch=0 -> done 2 cycles after start, no load_en.
- Interference: start and ch_done pulsed during WAIT_ACK -> ignored, sequence unchanged.
- Reset mid-sequence: rst in HOLD of channel 1 -> next cycle all outputs 0, state IDLE, no done.
- With CONV33_BIAS_ACK_TIMEOUT_EN and bias_load withheld -> err=1 after 15 WAIT_ACK cycles, return to IDLE, no done; next start clears err.
